// File: rtl/hit_score_pkg.sv
// Shared types for the hit/score game-state keeper: FSM states and packed BCD score types.
package hit_score_pkg;

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      INVULN    = 2'd1,
      GAME_OVER = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;
   typedef bcd_digit_t [3:0] bcd_score_t;

   localparam bcd_score_t BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_add_sat.sv
// Four-digit packed BCD adder of a single-digit increment, saturating at 9999.
// thousandsCarry flags a carry into the thousands digit that did not saturate.
module bcd_add_sat
   import hit_score_pkg::*;
(
   input  bcd_score_t score_in,
   input  bcd_digit_t inc,
   output bcd_score_t score_out,
   output logic       thousandsCarry
);

   bcd_score_t sum;
   logic [4:0] dsum;
   logic       c;
   logic       c_into3;

   always_comb begin
      sum     = '0;
      dsum    = '0;
      c       = 1'b0;
      c_into3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) c_into3 = c;
         dsum = {1'b0, score_in[i]} + {4'd0, c} + ((i == 0) ? {1'b0, inc} : 5'd0);
         if (dsum > 5'd9) begin
            sum[i] = 4'(dsum - 5'd10);
            c      = 1'b1;
         end else begin
            sum[i] = dsum[3:0];
            c      = 1'b0;
         end
      end
      score_out      = c ? BCD_MAX : sum;
      thousandsCarry = c_into3 & ~c;
   end

endmodule

// File: rtl/hit_score_manager.sv
// Frame-synchronous game-state keeper: BCD score, lives, invulnerability window, rope flag.
// Optional macro BONUS_LIFE_EN: each thousands-digit increment of the score grants one life.
//
// state     | meaning
// ----------+----------------------------------------------------------
// PLAY      | hazards seen in a frame cost a life at the next frame start
// INVULN    | hazards ignored; frame down-counter running
// GAME_OVER | lives exhausted; score frozen until restart
module hit_score_manager
   import hit_score_pkg::*;
#(
   parameter int unsigned POINTS_PER_HIT = 1,
   parameter int unsigned START_LIVES    = 3,
   parameter int unsigned MAX_LIVES      = 7,
   parameter int unsigned INVULN_FRAMES  = 60
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        numberHit,
   input  logic        hazardHit,
   input  logic        ropeCollision,
   input  logic        restart,
   output logic [15:0] score,
   output logic [2:0]  lives,
   output logic        invulnerable,
   output logic        onRope,
   output logic        lifeLostPulse,
   output logic        gameOver
);

   state_t     state_q, state_d;
   bcd_score_t score_q, score_d, score_sum;
   logic [2:0] lives_q, lives_d;
   logic [7:0] cnt_q, cnt_d;
   logic       haz_seen_q, haz_seen_d;
   logic       rope_seen_q, rope_seen_d;
   logic       on_rope_q, on_rope_d;
   logic       life_lost_q, life_lost_d;
   logic       life_loss, hit_ok, do_restart;

`ifdef BONUS_LIFE_EN
   logic       bonus_carry;
`else
   logic       bonus_carry_unused;
`endif

   bcd_add_sat u_bcd_add_sat (
      .score_in       (score_q),
      .inc            (4'(POINTS_PER_HIT)),
      .score_out      (score_sum),
`ifdef BONUS_LIFE_EN
      .thousandsCarry (bonus_carry)
`else
      .thousandsCarry (bonus_carry_unused)
`endif
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state_q <= PLAY;
      else         state_q <= state_d;
   end

   // Counter holds frames still to run; the frame start that takes it to zero exits INVULN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         PLAY:      if (startOfFrame && haz_seen_q) state_d = (lives_q > 3'd1) ? INVULN : GAME_OVER;
         INVULN:    if (startOfFrame && cnt_q == 8'd1) state_d = PLAY;
         GAME_OVER: if (restart) state_d = PLAY;
         default:   state_d = PLAY;
      endcase
   end

   always_comb begin
      life_loss  = startOfFrame && (state_q == PLAY) && haz_seen_q;
      hit_ok     = numberHit && (state_q != GAME_OVER);
      do_restart = (state_q == GAME_OVER) && restart;

      haz_seen_d  = startOfFrame ? hazardHit     : (haz_seen_q  | hazardHit);
      rope_seen_d = startOfFrame ? ropeCollision : (rope_seen_q | ropeCollision);
      on_rope_d   = startOfFrame ? rope_seen_q   : on_rope_q;
      life_lost_d = life_loss;
      score_d     = hit_ok ? score_sum : score_q;
      lives_d     = lives_q - {2'b00, life_loss};

      cnt_d = cnt_q;
      if (state_q == PLAY && state_d == INVULN)  cnt_d = 8'(INVULN_FRAMES);
      else if (state_q == INVULN && startOfFrame) cnt_d = cnt_q - 8'd1;

`ifdef BONUS_LIFE_EN
      // Losing the last life ends the game with zero lives even if a bonus coincides.
      if (hit_ok && bonus_carry && !(life_loss && lives_q == 3'd1)) begin
         if (lives_d >= 3'(MAX_LIVES)) lives_d = 3'(MAX_LIVES);
         else                          lives_d = lives_d + 3'd1;
      end
`endif

      if (do_restart) begin
         score_d     = '0;
         lives_d     = 3'(START_LIVES);
         haz_seen_d  = 1'b0;
         rope_seen_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         score_q     <= '0;
         lives_q     <= 3'(START_LIVES);
         cnt_q       <= '0;
         haz_seen_q  <= 1'b0;
         rope_seen_q <= 1'b0;
         on_rope_q   <= 1'b0;
         life_lost_q <= 1'b0;
      end else begin
         score_q     <= score_d;
         lives_q     <= lives_d;
         cnt_q       <= cnt_d;
         haz_seen_q  <= haz_seen_d;
         rope_seen_q <= rope_seen_d;
         on_rope_q   <= on_rope_d;
         life_lost_q <= life_lost_d;
      end
   end

   assign score         = score_q;
   assign lives         = lives_q;
   assign invulnerable  = (state_q == INVULN);
   assign gameOver      = (state_q == GAME_OVER);
   assign onRope        = on_rope_q;
   assign lifeLostPulse = life_lost_q;

endmodule

// File: doc/hit_score_manager.md
# hit_score_manager

Frame-synchronous game-state keeper on the receiving side of the collision controller. Consumes its per-pixel collision levels and its one-per-frame number-hit pulse, and turns them into game state: a 4-digit BCD score, a lives counter, an invulnerability window, a rope-contact flag, and game-over. Sits between the collision controller and the score/lives display and monkey movement blocks.

## Interface
Parameters:
- POINTS_PER_HIT, 1 — BCD points added per number hit; legal range 1..9.
- START_LIVES, 3 — lives loaded at reset and at restart; legal range 1..MAX_LIVES.
- MAX_LIVES, 7 — lives saturation value; must fit in 3 bits.
- INVULN_FRAMES, 60 — length of the invulnerability window in frames; legal range 1..255.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse at the start of each frame.
- numberHit  in  1  one-cycle pulse, at most one per frame (collision controller SingleHitPulse).
- hazardHit  in  1  level; monkey pixel overlaps a hazard pixel.
- ropeCollision  in  1  level; monkey pixel overlaps a rope pixel.
- restart  in  1  one-cycle pulse; honoured only in GAME_OVER.
- score  out  16  4-digit packed BCD, digit 3 in [15:12].
- lives  out  3  remaining lives.
- invulnerable  out  1  high in INVULN.
- onRope  out  1  rope contact occurred in the previous frame.
- lifeLostPulse  out  1  one-cycle pulse when a life is deducted.
- gameOver  out  1  high in GAME_OVER.

## Operation
- Reset values: score=0x0000, lives=START_LIVES, invulnerable=0, onRope=0, lifeLostPulse=0, gameOver=0, state=PLAY, frame counter=0.
- Frame accumulators hazSeen and ropeSeen OR-accumulate their inputs during a frame.
  - On a startOfFrame cycle each accumulator is evaluated, then reloaded with that cycle's input value. A hit in the startOfFrame cycle therefore belongs to the new frame.
- onRope <= ropeSeen on each startOfFrame. It is updated in every state.
- FSM states: PLAY, INVULN, GAME_OVER. All transitions happen only on startOfFrame, except GAME_OVER exit.
  - PLAY, hazSeen=1, lives>1: lives-1, lifeLostPulse=1, load counter with INVULN_FRAMES, go to INVULN.
  - PLAY, hazSeen=1, lives==1: lives=0, lifeLostPulse=1, go to GAME_OVER.
  - INVULN: hazSeen is ignored; counter decrements on each startOfFrame. When the counter reaches 0, go to PLAY on that same startOfFrame.
  - GAME_OVER: restart (any cycle) sets score=0, lives=START_LIVES, clears both accumulators, goes to PLAY.
- Score:
  - numberHit in PLAY or INVULN adds POINTS_PER_HIT as a BCD add with inter-digit carry.
  - The result saturates at 0x9999; digits never take values A–F.
  - numberHit in GAME_OVER is ignored.
- Simultaneous events:
  - numberHit together with a startOfFrame that costs the final life: the score is still updated, and the state still goes to GAME_OVER.
  - restart together with startOfFrame: restart wins.

## Timing
- All outputs are registered.
- score updates 1 cycle after numberHit.
- lives, lifeLostPulse, invulnerable, gameOver and onRope update 1 cycle after the evaluating startOfFrame.
- Invulnerability lasts exactly INVULN_FRAMES startOfFrame pulses after entry.
- Asserting resetN low mid-frame or mid-INVULN returns immediately to reset values; no pending hit survives.

## Configuration
- BONUS_LIFE_EN defined:
  - Each score update that increments the thousands digit (including via carry) also adds 1 life, saturating at MAX_LIVES.
  - If a bonus and a life loss coincide in one cycle, the net change is 0 and lifeLostPulse still fires.
  - A bonus in that cycle does not prevent GAME_OVER, because loss evaluation uses the pre-update lives.
  - No bonus is granted when the score saturates at 0x9999.
- BONUS_LIFE_EN undefined: lives only decrease or reload; no bonus logic is present.

## Structure
- Package hit_score_pkg holds:
  - the state enum (PLAY, INVULN, GAME_OVER);
  - the bcd_digit_t (4-bit) and bcd_score_t (4 digits) typedefs;
  - the BCD_MAX constant, 0x9999.
- Sub-module bcd_add_sat: combinational 4-digit BCD adder of a single-digit increment with saturation. It also outputs a thousandsCarry flag, used by BONUS_LIFE_EN.

## Test plan
- Reset, then 12 numberHit pulses one frame apart with POINTS_PER_HIT=1 -> score=0x0012, lives=3, no lifeLostPulse.
- Score preset to 0x0999, one numberHit -> score=0x1000. With BONUS_LIFE_EN lives 3->4; without it lives stay 3.
- hazardHit for 1 cycle mid-frame -> at the next startOfFrame, lives 3->2 and a 1-cycle lifeLostPulse, invulnerable=1. A hazard during the following 60 frames -> no change. invulnerable drops on the 60th startOfFrame.
- Three separated hazard hits, each outside INVULN -> lives=0, gameOver=1. A later numberHit leaves score unchanged. A restart pulse -> score=0x0000, lives=3, gameOver=0.
- Score at 0x9998, POINTS_PER_HIT=5, one numberHit -> score=0x9999. A further hit keeps score at 0x9999 and grants no bonus life.
- ropeCollision asserted only on the startOfFrame cycle of frame N -> onRope=0 after that startOfFrame, onRope=1 after the next one. resetN pulsed mid-INVULN -> all outputs return to reset values.
